// File: rtl/sd_stream_pkg.sv
// Shared definitions for the multi-sector SD streamer: fill FSM states and sector constants.
// No logic here; no latency or backpressure of its own.
package sd_stream_pkg;

    localparam int         SECTOR_BYTES = 512;
    localparam logic [3:0] CARD_IDLE    = 4'd8;

    typedef enum logic [2:0] {
        FILL_IDLE,
        FILL_WAIT_SLOT,
        FILL_ISSUE,
        FILL_WAIT_DONE,
        FILL_ERR
    } fill_state_e;

endpackage

// File: rtl/sd_sector_buf.sv
// Two-slot sector store, 1024x8, one write port and one registered read port.
// Read data appears one cycle after re_i and holds while re_i is low; no backpressure.
module sd_sector_buf (
    input  logic       clk,
    input  logic       we_i,
    input  logic [9:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic       re_i,
    input  logic [9:0] raddr_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [0:1023];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sd_multi_sector_streamer.sv
// Reads req_count sectors through a single-sector reader into two ping-pong slots and streams them out bytewise.
// First byte 2 cycles after the filling rd_done; m_ready low stalls the stream and, once both slots are full, further reads. Option: SD_STREAM_RETRY_EN.
module sd_multi_sector_streamer
    import sd_stream_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000,
    parameter int          MAX_RETRY      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_start,
    input  logic [31:0] req_sector,
    input  logic [15:0] req_count,
    output logic        req_busy,
    output logic        req_done,
    output logic        err,
    output logic        rd_start,
    output logic [31:0] rd_sector_no,
    input  logic        rd_done,
    input  logic [3:0]  rd_cardstate,
    input  logic        rd_rvalid,
    input  logic [8:0]  rd_raddr,
    input  logic [7:0]  rd_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_sector_last,
    output logic        m_last
);

`ifdef SD_STREAM_RETRY_EN
    localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);
`else
    // Retries disabled: any timeout is fatal.
    localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY) & 8'd0;
`endif
    localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 24'd1;
    localparam logic [8:0]  LAST_BYTE    = 9'(SECTOR_BYTES - 1);

    fill_state_e state_q, state_d;
    logic [31:0] sector_q, sector_d;
    logic [15:0] issue_left_q, issue_left_d;
    logic [15:0] rd_left_q, rd_left_d;
    logic [23:0] timer_q, timer_d;
    logic [7:0]  retry_q, retry_d;
    logic [1:0]  full_q, full_d;
    logic        fill_slot_q, fill_slot_d;
    logic        rd_slot_q, rd_slot_d;
    logic        out_slot_q, out_slot_d;
    logic [8:0]  rd_ptr_q, rd_ptr_d;
    logic        s1_vld_q, s1_vld_d;
    logic        s1_sl_q, s1_sl_d;
    logic        s1_last_q, s1_last_d;
    logic        m_valid_q, m_valid_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        m_sl_q, m_sl_d;
    logic        m_last_q, m_last_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        buf_we;
    logic [7:0]  buf_rdata;
    logic        m_hs, fill_done, flush, avail, load_out, rd_issue;

    sd_sector_buf u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i ({fill_slot_q, rd_raddr}),
        .wdata_i (rd_rdata),
        .re_i    (rd_issue),
        .raddr_i ({rd_slot_q, rd_ptr_q}),
        .rdata_o (buf_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL_IDLE;
            sector_q     <= '0;
            issue_left_q <= '0;
            rd_left_q    <= '0;
            timer_q      <= '0;
            retry_q      <= '0;
            full_q       <= '0;
            fill_slot_q  <= 1'b0;
            rd_slot_q    <= 1'b0;
            out_slot_q   <= 1'b0;
            rd_ptr_q     <= '0;
            s1_vld_q     <= 1'b0;
            s1_sl_q      <= 1'b0;
            s1_last_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_sl_q       <= 1'b0;
            m_last_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sector_q     <= sector_d;
            issue_left_q <= issue_left_d;
            rd_left_q    <= rd_left_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            full_q       <= full_d;
            fill_slot_q  <= fill_slot_d;
            rd_slot_q    <= rd_slot_d;
            out_slot_q   <= out_slot_d;
            rd_ptr_q     <= rd_ptr_d;
            s1_vld_q     <= s1_vld_d;
            s1_sl_q      <= s1_sl_d;
            s1_last_q    <= s1_last_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_sl_q       <= m_sl_d;
            m_last_q     <= m_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sector_d     = sector_q;
        issue_left_d = issue_left_q;
        rd_left_d    = rd_left_q;
        timer_d      = timer_q;
        retry_d      = retry_q;
        full_d       = full_q;
        fill_slot_d  = fill_slot_q;
        rd_slot_d    = rd_slot_q;
        out_slot_d   = out_slot_q;
        rd_ptr_d     = rd_ptr_q;
        s1_vld_d     = s1_vld_q;
        s1_sl_d      = s1_sl_q;
        s1_last_d    = s1_last_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_sl_d       = m_sl_q;
        m_last_d     = m_last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        rd_start     = 1'b0;
        buf_we       = 1'b0;
        fill_done    = 1'b0;
        flush        = 1'b0;
        m_hs         = m_valid_q && m_ready;

        case (state_q)
            FILL_IDLE: begin
                if (req_start && !busy_q) begin
                    err_d       = 1'b0;
                    sector_d    = req_sector;
                    full_d      = '0;
                    fill_slot_d = 1'b0;
                    rd_slot_d   = 1'b0;
                    out_slot_d  = 1'b0;
                    rd_ptr_d    = '0;
                    retry_d     = '0;
                    if (req_count == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d       = 1'b1;
                        issue_left_d = req_count;
                        rd_left_d    = req_count;
                        state_d      = FILL_WAIT_SLOT;
                    end
                end
            end
            FILL_WAIT_SLOT: begin
                if (!full_q[fill_slot_q]) begin
                    state_d = FILL_ISSUE;
                end
            end
            FILL_ISSUE: begin
                if (rd_cardstate == CARD_IDLE) begin
                    rd_start = 1'b1;
                    timer_d  = 24'd1;
                    state_d  = FILL_WAIT_DONE;
                end
            end
            FILL_WAIT_DONE: begin
                buf_we  = rd_rvalid;
                timer_d = timer_q + 24'd1;
                if (rd_done) begin
                    fill_done    = 1'b1;
                    retry_d      = '0;
                    fill_slot_d  = ~fill_slot_q;
                    sector_d     = sector_q + 32'd1;
                    issue_left_d = issue_left_q - 16'd1;
                    state_d      = (issue_left_q == 16'd1) ? FILL_IDLE : FILL_WAIT_SLOT;
                end else if (timer_q == TIMEOUT_LAST) begin
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + 8'd1;
                        state_d = FILL_ISSUE;
                    end else begin
                        flush   = 1'b1;
                        state_d = FILL_ERR;
                    end
                end
            end
            FILL_ERR: begin
                state_d = FILL_IDLE;
            end
            default: begin
                state_d = FILL_IDLE;
            end
        endcase

        if (fill_done) begin
            full_d[fill_slot_q] = 1'b1;
        end

        // The slot completing this cycle is readable at once so the first byte is not delayed by full_q.
        avail    = (full_q[rd_slot_q] || (fill_done && (fill_slot_q == rd_slot_q))) && (rd_left_q != 16'd0);
        load_out = s1_vld_q && (!m_valid_q || m_ready);
        rd_issue = avail && (!s1_vld_q || load_out);

        if (rd_issue) begin
            s1_vld_d  = 1'b1;
            s1_sl_d   = (rd_ptr_q == LAST_BYTE);
            s1_last_d = (rd_ptr_q == LAST_BYTE) && (rd_left_q == 16'd1);
            rd_ptr_d  = rd_ptr_q + 9'd1;
            if (rd_ptr_q == LAST_BYTE) begin
                rd_slot_d = ~rd_slot_q;
                rd_left_d = rd_left_q - 16'd1;
            end
        end else if (load_out) begin
            s1_vld_d = 1'b0;
        end

        if (load_out) begin
            m_valid_d = 1'b1;
            m_data_d  = buf_rdata;
            m_sl_d    = s1_sl_q;
            m_last_d  = s1_last_q;
        end else if (m_hs) begin
            m_valid_d = 1'b0;
        end

        if (m_hs && m_sl_q) begin
            full_d[out_slot_q] = 1'b0;
            out_slot_d         = ~out_slot_q;
        end
        if (m_hs && m_last_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end

        if (flush) begin
            full_d    = '0;
            rd_left_d = '0;
            s1_vld_d  = 1'b0;
            m_valid_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            err_d     = 1'b1;
        end
    end

    assign req_busy      = busy_q;
    assign req_done      = done_q;
    assign err           = err_q;
    assign rd_sector_no  = sector_q;
    assign m_valid       = m_valid_q;
    assign m_data        = m_data_q;
    assign m_sector_last = m_sl_q;
    assign m_last        = m_last_q;

endmodule
